// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: opcodes, FSM states,
// opcode classes and the ALU control field values.
package cpu_ctrl_pkg;

  localparam int OPCODE_W = 7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_NONE  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_ARITH  = 3'd3,
    CLS_BRANCH = 3'd4
  } opclass_t;

  function automatic opclass_t decode_class(input logic [6:0] op);
    case (op)
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_ARITH:  return CLS_ARITH;
      OP_BRANCH: return CLS_BRANCH;
      default:   return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_mc_perf_counters.sv
// Free-running cycle counter and retired-instruction counter; both wrap.
module perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             retire,
  output logic [CNT_W-1:0] cycleCnt,
  output logic [CNT_W-1:0] instrCnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCnt <= '0;
      instrCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + 1'b1;
      if (retire)
        instrCnt <= instrCnt + 1'b1;
    end
  end

endmodule

// File: rtl/control_fsm_mc.sv
// Multicycle control FSM with memory-ready watchdog. Performance counters are
// built only when PERF_CNT_EN is defined; otherwise cycleCnt/instrCnt read 0.
module control_fsm_mc
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15,
  parameter int OPCODE_W = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] instruc,
  input  logic                memReady,
  output logic                irWrite,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic                pcSource,
  output logic                iOrD,
  output logic                memRead,
  output logic                memWrite,
  output logic                memToReg,
  output logic                regWrite,
  output logic                aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic [1:0]          aluOp,
  output logic                illegal,
  output logic                memErr,
  output logic [3:0]          state,
  output logic [CNT_W-1:0]    cycleCnt,
  output logic [CNT_W-1:0]    instrCnt
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state_reg, state_next;
  opclass_t   class_reg, class_next;
  logic [7:0] wait_reg, wait_next;
  logic       illegal_reg, illegal_next;
  logic       memerr_reg, memerr_next;
  logic       mem_wait;
  logic       expire;
  logic       retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      class_reg   <= CLS_NONE;
      wait_reg    <= '0;
      illegal_reg <= 1'b0;
      memerr_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      class_reg   <= class_next;
      wait_reg    <= wait_next;
      illegal_reg <= illegal_next;
      memerr_reg  <= memerr_next;
    end
  end

  // Final wait cycle: a late memReady here still completes the access.
  assign expire = (wait_reg == WAIT_LAST) && !memReady;

  always_comb begin
    irWrite      = 1'b0;
    pcWrite      = 1'b0;
    pcWriteCond  = 1'b0;
    pcSource     = 1'b0;
    iOrD         = 1'b0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memToReg     = 1'b0;
    regWrite     = 1'b0;
    aluSrcA      = 1'b0;
    aluSrcB      = SRCB_RS2;
    aluOp        = ALU_NONE;
    state_next   = state_reg;
    class_next   = class_reg;
    illegal_next = 1'b0;
    memerr_next  = 1'b0;
    mem_wait     = 1'b0;
    retire       = 1'b0;

    case (state_reg)
      S_FETCH: begin
        memRead  = 1'b1;
        aluSrcB  = SRCB_FOUR;
        aluOp    = ALU_ADD;
        mem_wait = 1'b1;
        if (memReady) begin
          irWrite    = 1'b1;
          pcWrite    = 1'b1;
          state_next = S_DECODE;
        end else if (expire) begin
          memerr_next = 1'b1;
        end
      end
      S_DECODE: begin
        aluSrcB    = SRCB_IMM;
        aluOp      = ALU_ADD;
        class_next = decode_class(instruc);
        case (class_next)
          CLS_LOAD, CLS_STORE: state_next = S_MEM_ADDR;
          CLS_ARITH:           state_next = S_EXEC_R;
          CLS_BRANCH:          state_next = S_BRANCH;
          default: begin
            illegal_next = 1'b1;
            state_next   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        aluSrcA    = 1'b1;
        aluSrcB    = SRCB_IMM;
        aluOp      = ALU_ADD;
        state_next = (class_reg == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        memRead  = 1'b1;
        iOrD     = 1'b1;
        mem_wait = 1'b1;
        if (memReady) begin
          state_next = S_MEM_WB;
        end else if (expire) begin
          memerr_next = 1'b1;
          state_next  = S_FETCH;
        end
      end
      S_MEM_WB: begin
        regWrite   = 1'b1;
        memToReg   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        memWrite = 1'b1;
        iOrD     = 1'b1;
        mem_wait = 1'b1;
        if (memReady) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (expire) begin
          memerr_next = 1'b1;
          state_next  = S_FETCH;
        end
      end
      S_EXEC_R: begin
        aluSrcA    = 1'b1;
        aluOp      = ALU_FUNCT;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        regWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = ALU_SUB;
        pcWriteCond = 1'b1;
        pcSource    = 1'b1;
        retire      = 1'b1;
        state_next  = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // Any state entry (including an abort back into FETCH) restarts the watchdog.
    if ((state_next != state_reg) || memerr_next)
      wait_next = '0;
    else if (mem_wait && !memReady)
      wait_next = wait_reg + 8'd1;
    else
      wait_next = wait_reg;
  end

  assign illegal = illegal_reg;
  assign memErr  = memerr_reg;
  assign state   = state_reg;

`ifdef PERF_CNT_EN
  perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk      (clk),
    .reset    (reset),
    .retire   (retire),
    .cycleCnt (cycleCnt),
    .instrCnt (instrCnt)
  );
`else
  assign cycleCnt = '0;
  assign instrCnt = '0;
`endif

endmodule

// File: tb/tb_control_fsm_mc.sv
// Scoreboard bench for control_fsm_mc: per-cycle expected outputs are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_control_fsm_mc;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] AR  = 7'b0110011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b0010011;

  // {irWrite,pcWrite,pcWriteCond,pcSource,iOrD,memRead,memWrite,memToReg,
  //  regWrite,aluSrcA,aluSrcB[1:0],aluOp[1:0],illegal,memErr}
  localparam logic [15:0] C_FW  = 16'h0410;
  localparam logic [15:0] C_FR  = 16'hC410;
  localparam logic [15:0] C_DEC = 16'h0020;
  localparam logic [15:0] C_MA  = 16'h0060;
  localparam logic [15:0] C_MRD = 16'h0C0C;
  localparam logic [15:0] C_MWB = 16'h018C;
  localparam logic [15:0] C_MWR = 16'h0A0C;
  localparam logic [15:0] C_EXR = 16'h0048;
  localparam logic [15:0] C_AWB = 16'h008C;
  localparam logic [15:0] C_BR  = 16'h3044;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  instruc = '0;
  logic        memReady = 1'b0;
  logic        irWrite, pcWrite, pcWriteCond, pcSource, iOrD, memRead, memWrite;
  logic        memToReg, regWrite, aluSrcA, illegal, memErr;
  logic [1:0]  aluSrcB, aluOp;
  logic [3:0]  state;
  logic [31:0] cycleCnt, instrCnt;
  logic [15:0] act_ctl;

  typedef struct {
    string       nm;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [31:0] ic;
    logic [31:0] cc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] instr_exp = 0;
  logic [31:0] cyc_exp = 0;

  control_fsm_mc #(.CNT_W(32), .WAIT_MAX(4), .OPCODE_W(7)) dut (
    .clk(clk), .reset(reset), .instruc(instruc), .memReady(memReady),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
    .pcSource(pcSource), .iOrD(iOrD), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .regWrite(regWrite), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluOp(aluOp), .illegal(illegal), .memErr(memErr),
    .state(state), .cycleCnt(cycleCnt), .instrCnt(instrCnt)
  );

  always #5 clk = ~clk;

  assign act_ctl = {irWrite, pcWrite, pcWriteCond, pcSource, iOrD, memRead, memWrite,
                    memToReg, regWrite, aluSrcA, aluSrcB, aluOp, illegal, memErr};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".state"}, 32'(state), 32'(e.st));
      chk({e.nm, ".ctl"}, 32'(act_ctl), 32'(e.ctl));
      chk({e.nm, ".instrCnt"}, instrCnt, e.ic);
      chk({e.nm, ".cycleCnt"}, cycleCnt, e.cc);
      $display("cycle %-10s state=%0d ctl=%h instrCnt=%0d cycleCnt=%0d",
               e.nm, state, act_ctl, instrCnt, cycleCnt);
    end
  end

  task automatic push(input string nm, input logic [3:0] st, input logic [15:0] ctl);
    exp_t e;
    e.nm = nm;
    e.st = st;
    e.ctl = ctl;
`ifdef PERF_CNT_EN
    e.ic = instr_exp;
    e.cc = cyc_exp;
`else
    e.ic = 0;
    e.cc = 0;
`endif
    q.push_back(e);
  endtask

  task automatic step(input string nm, input logic [6:0] op, input logic rdy,
                      input logic [3:0] st, input logic [15:0] ctl, input bit ret);
    instruc = op;
    memReady = rdy;
    push(nm, st, ctl);
    if (ret) instr_exp++;
    cyc_exp++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.ctl", 32'(act_ctl), 32'(C_FW));
    chk("rst.cnt", instrCnt | cycleCnt, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // LOAD, memReady always high: 5 cycles
    step("ld_f",   LD, 1, 4'd0, C_FR,  0);
    step("ld_d",   LD, 1, 4'd1, C_DEC, 0);
    step("ld_a",   LD, 1, 4'd2, C_MA,  0);
    step("ld_rd",  LD, 1, 4'd3, C_MRD, 0);
    step("ld_wb",  LD, 1, 4'd4, C_MWB, 1);
    // STORE, 3 wait cycles in MEM_WR; ready on the last allowed wait cycle
    step("st_f",   ST, 1, 4'd0, C_FR,  0);
    step("st_d",   ST, 1, 4'd1, C_DEC, 0);
    step("st_a",   ST, 1, 4'd2, C_MA,  0);
    step("st_w0",  ST, 0, 4'd5, C_MWR, 0);
    step("st_w1",  ST, 0, 4'd5, C_MWR, 0);
    step("st_w2",  ST, 0, 4'd5, C_MWR, 0);
    step("st_w3",  ST, 1, 4'd5, C_MWR, 1);
    // ARITH then BRANCH back to back
    step("ar_f",   AR, 1, 4'd0, C_FR,  0);
    step("ar_d",   AR, 1, 4'd1, C_DEC, 0);
    step("ar_ex",  AR, 1, 4'd6, C_EXR, 0);
    step("ar_wb",  AR, 1, 4'd7, C_AWB, 1);
    step("br_f",   BR, 1, 4'd0, C_FR,  0);
    step("br_d",   BR, 1, 4'd1, C_DEC, 0);
    step("br_x",   BR, 1, 4'd8, C_BR,  1);
    // Illegal opcode, then fetch watchdog expiry with no memReady
    step("il_f",   BAD, 1, 4'd0, C_FR,  0);
    step("il_d",   BAD, 1, 4'd1, C_DEC, 0);
    step("wd_w1",  BAD, 0, 4'd0, C_FW | 16'h0002, 0);
    step("wd_w2",  BAD, 0, 4'd0, C_FW,  0);
    step("wd_w3",  BAD, 0, 4'd0, C_FW,  0);
    step("wd_w4",  BAD, 0, 4'd0, C_FW,  0);
    // Restarted fetch: memReady arrives on the 4th wait cycle
    step("wr_w1",  BR, 0, 4'd0, C_FW | 16'h0001, 0);
    step("wr_w2",  BR, 0, 4'd0, C_FW,  0);
    step("wr_w3",  BR, 0, 4'd0, C_FW,  0);
    step("wr_w4",  BR, 1, 4'd0, C_FR,  0);
    step("wr_d",   BR, 1, 4'd1, C_DEC, 0);
    step("wr_br",  BR, 1, 4'd8, C_BR,  1);
    // LOAD interrupted by asynchronous reset while in MEM_RD
    step("ar2_f",  LD, 1, 4'd0, C_FR,  0);
    step("ar2_d",  LD, 1, 4'd1, C_DEC, 0);
    step("ar2_a",  LD, 1, 4'd2, C_MA,  0);
    instruc = LD;
    memReady = 1'b0;
    push("ar2_rd", 4'd3, C_MRD);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst.state", 32'(state), 32'd0);
    chk("arst.we", 32'({irWrite, pcWrite, pcWriteCond, memWrite, regWrite}), 32'd0);
    chk("arst.instrCnt", instrCnt, 32'd0);
    chk("arst.cycleCnt", cycleCnt, 32'd0);
    instr_exp = 0;
    cyc_exp = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    step("post_rst", LD, 0, 4'd0, C_FW, 0);
    step("post_f",   LD, 1, 4'd0, C_FR, 0);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_fsm_mc.md
Name: control_fsm_mc

Overview:
Multicycle control unit for the RISC-V core. It is the successor to the single-cycle opcode decoder. It sequences each instruction through the Fetch, Decode, Execute/Address, Memory and Writeback steps. It drives datapath enables per state and waits on a memory ready handshake. A watchdog and optional performance counters are included. It sits between the IR opcode field and the shared-memory multicycle datapath.

Parameters:
CNT_W, 32, width of performance counters
WAIT_MAX, 15, max cycles a memory state waits for memReady before abort; range 1..255
OPCODE_W, 7, opcode field width; fixed at 7, present for package consistency

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
instruc  in  OPCODE_W  opcode field from IR; valid from DECODE onward
memReady  in  1  memory completes the current access this cycle
irWrite  out  1  load IR
pcWrite  out  1  unconditional PC write
pcWriteCond  out  1  PC write if ALU zero (branch)
pcSource  out  1  0 = ALU result, 1 = ALUOut register
iOrD  out  1  memory address: 0 = PC, 1 = ALUOut
memRead  out  1  memory read request
memWrite  out  1  memory write request
memToReg  out  1  writeback source: 1 = MDR, 0 = ALUOut
regWrite  out  1  register file write
aluSrcA  out  1  0 = PC, 1 = rs1
aluSrcB  out  2  00 = rs2, 01 = const 4, 10 = imm
aluOp  out  2  00 = add, 01 = sub/compare, 10 = funct decode, 11 = none
illegal  out  1  one-cycle pulse: unsupported opcode
memErr  out  1  one-cycle pulse: watchdog expired
state  out  4  current state encoding, for debug
cycleCnt  out  CNT_W  cycles since reset (optional feature)
instrCnt  out  CNT_W  retired instructions (optional feature)

Behaviour:
- Reset (async): state = FETCH; wait counter = 0; class register = NONE; counters = 0.
- All outputs are Moore (decoded from state only), except the gated irWrite and pcWrite in FETCH.
- Unlisted outputs are 0 in every state; aluOp defaults to 11.
- FETCH:
  - Drives memRead=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=00.
  - irWrite and pcWrite are asserted only in the cycle where memReady=1; that cycle then moves to DECODE.
- DECODE:
  - Drives aluSrcA=0, aluSrcB=10, aluOp=00 to precompute the branch target.
  - Latches the opcode class, then branches on instruc:
    - 0000011 LOAD or 0100011 STORE -> MEM_ADDR.
    - 0110011 ARITH -> EXEC_R.
    - 1100011 BRANCH -> BRANCH.
    - Any other opcode -> FETCH with illegal=1 for one cycle. Not retired.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to MEM_RD if the class is LOAD, otherwise MEM_WR.
- MEM_RD: memRead=1, iOrD=1. Waits for memReady, then goes to MEM_WB.
- MEM_WB: regWrite=1, memToReg=1, then FETCH. Retires.
- MEM_WR: memWrite=1, iOrD=1. Waits for memReady, then goes to FETCH. Retires.
- EXEC_R: aluSrcA=1, aluSrcB=00, aluOp=10, then ALU_WB.
- ALU_WB: regWrite=1, memToReg=0, then FETCH. Retires.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=1, then FETCH. Retires.
- Latency (memReady=1 on first request):
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - ARITH: 4 cycles.
  - BRANCH: 3 cycles.
  - Each memory wait cycle adds 1.
- Watchdog:
  - The wait counter clears on entry to FETCH, MEM_RD and MEM_WR.
  - It increments each cycle memReady=0 in those states.
  - When it reaches WAIT_MAX with memReady still 0, the FSM pulses memErr and goes to FETCH with no writes. The aborted instruction is not retired.
  - memReady=1 in the same cycle as expiry wins: normal completion, no memErr.
- memReady is ignored outside FETCH, MEM_RD and MEM_WR.
- Reset mid-instruction aborts immediately. No write enable may be asserted in the cycle after reset deassertion, because FETCH asserts none without memReady.

Optional Feature:
PERF_CNT_EN:
- Defined:
  - cycleCnt increments every cycle.
  - instrCnt increments on each retire event.
  - Both wrap modulo 2^CNT_W with no saturation.
  - Retire events: leaving MEM_WB, ALU_WB, BRANCH, or MEM_WR with memReady.
- Undefined: both outputs are tied to 0 and no counter flops are inferred.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants OP_LOAD, OP_STORE, OP_ARITH, OP_BRANCH;
  - state enum typedef (4-bit);
  - opcode class enum (NONE, LOAD, STORE, ARITH, BRANCH);
  - aluOp and aluSrcB encodings.
- One sub-module: perf_counters (cycle and retire counters), instantiated only under PERF_CNT_EN.

Test Plan:
- Reset asserted mid-MEM_RD -> state=FETCH asynchronously; all write enables 0; counters 0.
- LOAD, memReady held 1 -> state sequence FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; regWrite and memToReg 1 only in cycle 5; instrCnt=1.
- STORE with memReady low for 3 cycles in MEM_WR -> memWrite held 4 cycles; total 7 cycles; no memErr.
- ARITH, then BRANCH, back to back -> aluOp 10 in EXEC_R; pcWriteCond=1 in the BRANCH cycle; instrCnt=2 after 7 cycles.
- Opcode 0010011 -> illegal pulses 1 cycle; FETCH follows; instrCnt unchanged.
- WAIT_MAX=4, memReady=0 in FETCH:
  - memErr pulses after 4 wait cycles; irWrite never asserted.
  - Repeat with memReady=1 on the 4th wait cycle -> irWrite asserted and no memErr.
